// File: rtl/lane_judge.sv
// lane_judge: per-lane timing judge for one arrow column.
// Synchronizes the lane button, detects its rising edge, grades the distance
// of the lowest pending note from the receptor line, and emits registered
// one-cycle judgement / miss pulses plus a saturating combo counter.
module lane_judge #(
  parameter int CORDW     = 10,
  parameter int TARGET_Y  = 40,
  parameter int MARV_WIN  = 3,
  parameter int PERF_WIN  = 6,
  parameter int GREAT_WIN = 10,
  parameter int GOOD_WIN  = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             button_i,
  input  logic             note_valid_i,
  input  logic [CORDW-1:0] note_y_i,
  output logic [3:0]       judge_o,
  output logic             miss_o,
  output logic             hit_o,
  output logic [7:0]       combo_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // All distance arithmetic is one bit wider than the coordinate so that
  // y + GOOD_WIN never wraps and |y - TARGET_Y| is always representable.
  localparam logic [CORDW:0] LP_TARGET = (CORDW+1)'(TARGET_Y);
  localparam logic [CORDW:0] LP_MARV   = (CORDW+1)'(MARV_WIN);
  localparam logic [CORDW:0] LP_PERF   = (CORDW+1)'(PERF_WIN);
  localparam logic [CORDW:0] LP_GREAT  = (CORDW+1)'(GREAT_WIN);
  localparam logic [CORDW:0] LP_GOOD   = (CORDW+1)'(GOOD_WIN);

  logic             r_s1, r_s2, r_s3;
  logic [1:0]       r_state;
  logic [3:0]       r_judge;
  logic             r_miss;
  logic             r_hit;
  logic [7:0]       r_combo;

  logic             w_press;
  logic [CORDW:0]   w_y_ext;
  logic [CORDW:0]   w_dist;
  logic             w_late;
  logic [3:0]       w_grade;

  assign w_press = r_s2 & ~r_s3;
  assign w_y_ext = {1'b0, note_y_i};
  assign w_late  = (w_y_ext + LP_GOOD) < LP_TARGET;

  // Absolute distance of the note from the receptor line, and its grade.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    w_dist  = '0;
    w_grade = 4'b0000;
    if (w_y_ext >= LP_TARGET) w_dist = w_y_ext - LP_TARGET;
    else                      w_dist = LP_TARGET - w_y_ext;
    if      (w_dist <= LP_MARV)  w_grade = 4'b1000;
    else if (w_dist <= LP_PERF)  w_grade = 4'b0100;
    else if (w_dist <= LP_GREAT) w_grade = 4'b0010;
    else if (w_dist <= LP_GOOD)  w_grade = 4'b0001;
  end

  // Two-flop synchronizer for the raw button plus the edge-detect register.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is sampled on the clock edge here, and all state updates
    // use non-blocking assignments so every flop sees pre-edge values.
    if (!rst_ni) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= button_i;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Note FSM with registered one-cycle judgement/miss pulses and combo count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_judge <= 4'b0000;
      r_miss  <= 1'b0;
      r_hit   <= 1'b0;
      r_combo <= 8'd0;
    end else begin
      // Pulses default low so each one lasts exactly one cycle.
      r_judge <= 4'b0000;
      r_miss  <= 1'b0;
      r_hit   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (note_valid_i) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!note_valid_i) begin
            // Note vanished before being judged.
            r_miss  <= 1'b1;
            r_combo <= 8'd0;
            r_state <= ST_IDLE;
          end else if (w_press && (w_grade != 4'b0000)) begin
            // A qualifying press wins over late even if windows overlap.
            r_judge <= w_grade;
            r_hit   <= 1'b1;
            if (r_combo != 8'hFF) r_combo <= r_combo + 8'd1;
            r_state <= ST_DONE;
          end else if (w_late) begin
            r_miss  <= 1'b1;
            r_combo <= 8'd0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!note_valid_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign judge_o = r_judge;
  assign miss_o  = r_miss;
  assign hit_o   = r_hit;
  assign combo_o = r_combo;

endmodule

// File: tb/tb_lane_judge.sv
// tb_lane_judge: directed, table-driven bench for lane_judge with default
// parameters (TARGET_Y=40, windows 3/6/10/15).
module tb_lane_judge;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic       note_valid;
  logic [9:0] note_y;
  logic [3:0] judge;
  logic       miss;
  logic       hit;
  logic [7:0] combo;

  lane_judge dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .button_i     (button),
    .note_valid_i (note_valid),
    .note_y_i     (note_y),
    .judge_o      (judge),
    .miss_o       (miss),
    .hit_o        (hit),
    .combo_o      (combo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] y;
    logic [3:0] exp_judge;
  } vec_t;

  vec_t vecs [10];

  int n_checks = 0;
  int n_errors = 0;

  // Pulse statistics accumulated by step() since the last clear_counts().
  logic [3:0] acc_judge;
  int         acc_jcnt;
  int         acc_mcnt;
  int         acc_hcnt;
  int         acc_first;
  int         acc_cyc;
  int         viol;
  int         exp_combo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    acc_judge = 4'b0000;
    acc_jcnt  = 0;
    acc_mcnt  = 0;
    acc_hcnt  = 0;
    acc_first = -1;
    acc_cyc   = 0;
  endtask

  // Advance n cycles, sampling outputs 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      acc_cyc++;
      if (judge != 4'b0000) begin
        acc_jcnt++;
        if (acc_first < 0) acc_first = acc_cyc;
      end
      acc_judge |= judge;
      if (miss) acc_mcnt++;
      if (hit)  acc_hcnt++;
      if (hit != (judge != 4'b0000))  viol++;
      if (miss && (judge != 4'b0000)) viol++;
      if ($countones(judge) > 1)      viol++;
    end
  endtask

  task automatic note_on(input logic [9:0] y);
    note_valid = 1'b1;
    note_y     = y;
    step(2);
  endtask

  task automatic press(input int n);
    button = 1'b1;
    step(n);
    button = 1'b0;
    step(3);
  endtask

  task automatic note_off();
    note_valid = 1'b0;
    step(3);
  endtask

  // Full note: arm, press, release the note; statistics cover press onward.
  task automatic hit_note(input logic [9:0] y);
    note_on(y);
    clear_counts();
    press(8);
    note_off();
  endtask

  initial begin
    vecs[0] = '{10'd42, 4'b1000};
    vecs[1] = '{10'd35, 4'b0100};
    vecs[2] = '{10'd50, 4'b0010};
    vecs[3] = '{10'd25, 4'b0001};
    vecs[4] = '{10'd37, 4'b1000};
    vecs[5] = '{10'd34, 4'b0100};
    vecs[6] = '{10'd30, 4'b0010};
    vecs[7] = '{10'd55, 4'b0001};
    vecs[8] = '{10'd43, 4'b1000};
    vecs[9] = '{10'd46, 4'b0100};

    viol       = 0;
    exp_combo  = 0;
    rst_n      = 1'b0;
    button     = 1'b0;
    note_valid = 1'b0;
    note_y     = 10'd0;
    clear_counts();
    step(3);
    check("reset_judge", judge, 0);
    check("reset_miss",  miss,  0);
    check("reset_hit",   hit,   0);
    check("reset_combo", combo, 0);
    rst_n = 1'b1;
    step(2);

    // Table: one armed note per vector, single press, graded result.
    foreach (vecs[k]) begin
      hit_note(vecs[k].y);
      exp_combo++;
      check($sformatf("vec%0d_judge", k), acc_judge, vecs[k].exp_judge);
      check($sformatf("vec%0d_jcnt", k),  acc_jcnt,  1);
      check($sformatf("vec%0d_hcnt", k),  acc_hcnt,  1);
      check($sformatf("vec%0d_mcnt", k),  acc_mcnt,  0);
      check($sformatf("vec%0d_lat", k),   acc_first, 3);
      check($sformatf("vec%0d_combo", k), combo,     exp_combo);
    end

    // Out-of-window press is ignored; a later on-target press still judges.
    note_on(10'd60);
    clear_counts();
    press(8);
    check("far_jcnt", acc_jcnt, 0);
    check("far_mcnt", acc_mcnt, 0);
    note_y = 10'd40;
    clear_counts();
    press(8);
    exp_combo++;
    check("far_then_hit_judge", acc_judge, 4'b1000);
    check("far_then_hit_combo", combo, exp_combo);
    note_off();

    // Late miss: y=26 and y=25 are still in play, y=24 is past the window.
    note_on(10'd26);
    clear_counts();
    step(2);
    check("y26_mcnt", acc_mcnt, 0);
    note_y = 10'd25;
    step(2);
    check("y25_mcnt", acc_mcnt, 0);
    note_y = 10'd24;
    step(2);
    exp_combo = 0;
    check("y24_mcnt",  acc_mcnt, 1);
    check("y24_combo", combo, 0);
    clear_counts();
    press(8);
    check("done_press_jcnt", acc_jcnt, 0);
    note_off();
    check("done_off_mcnt", acc_mcnt, 0);

    // Held button judges once; a repeat press in DONE does nothing.
    note_on(10'd40);
    clear_counts();
    button = 1'b1;
    step(100);
    button = 1'b0;
    step(3);
    exp_combo++;
    check("held_jcnt",  acc_jcnt, 1);
    check("held_hcnt",  acc_hcnt, 1);
    clear_counts();
    press(8);
    check("repress_jcnt", acc_jcnt, 0);
    note_off();
    hit_note(10'd40);
    exp_combo++;
    check("rearm_judge", acc_judge, 4'b1000);
    check("rearm_combo", combo, exp_combo);

    // Note vanishing while ARMED is a miss.
    note_on(10'd60);
    clear_counts();
    note_off();
    exp_combo = 0;
    check("vanish_mcnt",  acc_mcnt, 1);
    check("vanish_combo", combo, 0);

    // Combo saturation at 255.
    while (exp_combo < 255) begin
      hit_note(10'd40);
      exp_combo++;
    end
    check("combo_255", combo, 255);
    hit_note(10'd41);
    check("sat_judge", acc_judge, 4'b1000);
    check("sat_combo", combo, 255);

    // Reset while ARMED drops the note silently; button held through reset.
    note_on(10'd60);
    clear_counts();
    rst_n  = 1'b0;
    button = 1'b1;
    note_y = 10'd40;
    step(3);
    check("midrst_mcnt",  acc_mcnt, 0);
    check("midrst_combo", combo, 0);
    check("midrst_judge", judge, 0);
    rst_n = 1'b1;
    clear_counts();
    step(12);
    check("rstheld_jcnt",  acc_jcnt, 1);
    check("rstheld_judge", acc_judge, 4'b1000);
    check("rstheld_combo", combo, 1);
    button = 1'b0;
    note_off();

    check("pulse_invariants", viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
